program_loader: RTL and testbench

- Writer side of the processor's program memory: receives a program as a byte stream and writes 29-bit instructions into program memory starting at address 0.
- Holds the processor in reset while a load is in progress.
- Sits between a byte source (UART/debug link) and the program memory write port; drives the processor reset.

---
 rtl/program_loader.sv | 144 ++++++++++++++
 tb/tb_program_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Program memory loader: turns a counted, checksummed byte stream into 29-bit
// instruction writes and holds the processor in reset until a load completes cleanly.
module program_loader #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 29
) (
  input  logic               in_clk,
  input  logic               in_rst,
  input  logic               in_start,
  input  logic [7:0]         in_byte,
  input  logic               in_byte_valid,
  output logic               out_byte_ready,
  output logic               out_pm_wr_en,
  output logic [ADDR_W-1:0]  out_pm_wr_addr,
  output logic [INSTR_W-1:0] out_pm_wr_data,
  output logic               out_cpu_rst_n,
  output logic               out_busy,
  output logic               out_done,
  output logic               out_error
);

  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_DATA, S_CHECK, S_DONE, S_ERROR} state_t;

  state_t               state_q, state_d;
  logic [7:0]           acc_q, acc_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [8:0]           cnt_q, cnt_d;
  logic [1:0]           idx_q, idx_d;
  logic [INSTR_W-9:0]   asm_q, asm_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [INSTR_W-1:0]   wr_data_q, wr_data_d;
  logic                 cpu_rst_n_q, cpu_rst_n_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic                 accept;

  assign out_byte_ready = (state_q == S_COUNT) || (state_q == S_DATA) || (state_q == S_CHECK);
  assign out_busy       = out_byte_ready;
  assign accept         = in_byte_valid && out_byte_ready;

  assign out_pm_wr_en   = wr_en_q;
  assign out_pm_wr_addr = wr_addr_q;
  assign out_pm_wr_data = wr_data_q;
  assign out_cpu_rst_n  = cpu_rst_n_q;
  assign out_done       = done_q;
  assign out_error      = error_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    cpu_rst_n_d = cpu_rst_n_q;
    done_d      = done_q;
    error_d     = error_q;
    case (state_q)
      S_IDLE: if (in_start) state_d = S_COUNT;
      S_COUNT: if (accept) begin
        acc_d   = in_byte;
        addr_d  = '0;
        idx_d   = '0;
        // A count byte of zero means a full 256-instruction image.
        cnt_d   = (in_byte == 8'h00) ? 9'd256 : {1'b0, in_byte};
        state_d = S_DATA;
      end
      S_DATA: if (accept) begin
        acc_d = acc_q ^ in_byte;
        if (idx_q == 2'd0 && in_byte[7:5] != 3'b000) begin
          state_d = S_ERROR;
          error_d = 1'b1;
        end else if (idx_q == 2'd3) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = {asm_q, in_byte};
          addr_d    = addr_q + ADDR_W'(1);
          cnt_d     = cnt_q - 9'd1;
          idx_d     = 2'd0;
          if (cnt_q == 9'd1) state_d = S_CHECK;
        end else begin
          // Oldest byte's top three bits fall off; they were verified zero at index 0.
          asm_d = {asm_q[INSTR_W-17:0], in_byte};
          idx_d = idx_q + 2'd1;
        end
      end
      S_CHECK: if (accept) begin
        if (in_byte == acc_q) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          cpu_rst_n_d = 1'b1;
        end else begin
          state_d = S_ERROR;
          error_d = 1'b1;
        end
      end
      S_DONE: if (in_start) begin
        state_d     = S_COUNT;
        done_d      = 1'b0;
        cpu_rst_n_d = 1'b0;
      end
      S_ERROR: if (in_start) begin
        state_d = S_COUNT;
        error_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      asm_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: per-cycle vector table plus multi-cycle
// sequences for gaps, full memory, async reset and reload.
module tb_program_loader;

  localparam int ST_IDLE = 0, ST_BUSY = 1, ST_DONE = 2, ST_ERR = 3;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic        start;
    logic        vld;
    logic [7:0]  b;
    int          st;
    logic        wr;
    logic [7:0]  addr;
    logic [28:0] data;
  } vec_t;
  typedef struct {
    logic [7:0]  addr;
    logic [28:0] data;
  } wr_t;

  logic        in_clk = 1'b0;
  logic        in_rst;
  logic        in_start;
  logic [7:0]  in_byte;
  logic        in_byte_valid;
  logic        out_byte_ready, out_pm_wr_en, out_cpu_rst_n, out_busy, out_done, out_error;
  logic [7:0]  out_pm_wr_addr;
  logic [28:0] out_pm_wr_data;

  int   n_chk = 0;
  int   n_fail = 0;
  vec_t vecs[$];
  wr_t  wq[$];

  program_loader #(.ADDR_W(8), .INSTR_W(29)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_start(in_start), .in_byte(in_byte),
    .in_byte_valid(in_byte_valid), .out_byte_ready(out_byte_ready),
    .out_pm_wr_en(out_pm_wr_en), .out_pm_wr_addr(out_pm_wr_addr),
    .out_pm_wr_data(out_pm_wr_data), .out_cpu_rst_n(out_cpu_rst_n),
    .out_busy(out_busy), .out_done(out_done), .out_error(out_error)
  );

  always #5 in_clk = ~in_clk;

  always @(negedge in_clk)
    if (out_pm_wr_en) wq.push_back('{addr: out_pm_wr_addr, data: out_pm_wr_data});

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int st);
    chk({tag, "_ready"}, 32'(out_byte_ready), 32'(st == ST_BUSY));
    chk({tag, "_busy"},  32'(out_busy),       32'(st == ST_BUSY));
    chk({tag, "_done"},  32'(out_done),       32'(st == ST_DONE));
    chk({tag, "_error"}, 32'(out_error),      32'(st == ST_ERR));
    chk({tag, "_cpurn"}, 32'(out_cpu_rst_n),  32'(st == ST_DONE));
  endtask

  task automatic add(input logic s, input logic v, input logic [7:0] b, input int st,
                     input logic w, input logic [7:0] a, input logic [28:0] d);
    vecs.push_back('{start: s, vld: v, b: b, st: st, wr: w, addr: a, data: d});
  endtask

  // Nominal two-instruction stream, one byte per cycle, ending in checksum byte cks.
  task automatic add_nominal(input logic [7:0] cks, input int end_st);
    add(0, 1, 8'h02, ST_BUSY, 0, 8'h00, 29'h0);
    add(0, 1, 8'h01, ST_BUSY, 0, 8'h00, 29'h0);
    add(0, 1, 8'h02, ST_BUSY, 0, 8'h00, 29'h0);
    add(0, 1, 8'h03, ST_BUSY, 0, 8'h00, 29'h0);
    add(0, 1, 8'h04, ST_BUSY, 1, 8'h00, 29'h01020304);
    add(0, 1, 8'h1F, ST_BUSY, 0, 8'h00, 29'h0);
    add(0, 0, 8'hAA, ST_BUSY, 0, 8'h00, 29'h0);
    add(0, 1, 8'hFF, ST_BUSY, 0, 8'h00, 29'h0);
    add(0, 1, 8'hFF, ST_BUSY, 0, 8'h00, 29'h0);
    add(0, 1, 8'hFF, ST_BUSY, 1, 8'h01, 29'h1FFFFFFF);
    add(0, 1, cks,   end_st,  0, 8'h00, 29'h0);
  endtask

  task automatic send_stream(input bq_t bs, input bit gaps, input int start_idx);
    for (int i = 0; i < bs.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge in_clk);
      in_byte       = bs[i];
      in_byte_valid = 1'b1;
      in_start      = (i == start_idx);
      begin
        int k = 0;
        while (!out_byte_ready && k < 20) begin
          @(negedge in_clk);
          k++;
        end
        if (k == 20) chk($sformatf("ready_timeout_b%0d", i), 32'(out_byte_ready), 32'd1);
      end
      @(negedge in_clk);
      in_byte_valid = 1'b0;
      in_start      = 1'b0;
    end
  endtask

  task automatic pulse_start();
    in_start = 1'b1;
    @(negedge in_clk);
    in_start = 1'b0;
  endtask

  task automatic chk_nominal_writes(input string tag);
    chk({tag, "_nwr"}, 32'(wq.size()), 32'd2);
    if (wq.size() == 2) begin
      chk({tag, "_a0"}, 32'(wq[0].addr), 32'h00);
      chk({tag, "_d0"}, 32'(wq[0].data), 32'h01020304);
      chk({tag, "_a1"}, 32'(wq[1].addr), 32'h01);
      chk({tag, "_d1"}, 32'(wq[1].data), 32'h1FFFFFFF);
    end
  endtask

  initial begin
    bq_t nom, full;
    nom = '{8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h1F, 8'hFF, 8'hFF, 8'hFF, 8'hE6};

    // Vector table: IDLE bytes ignored, nominal load, reload to bad checksum,
    // format error, recovery with a good load.
    add(0, 1, 8'h55, ST_IDLE, 0, 8'h00, 29'h0);
    add(1, 0, 8'h00, ST_BUSY, 0, 8'h00, 29'h0);
    add_nominal(8'hE6, ST_DONE);
    add(0, 0, 8'h00, ST_DONE, 0, 8'h00, 29'h0);
    add(1, 0, 8'h00, ST_BUSY, 0, 8'h00, 29'h0);
    add_nominal(8'h00, ST_ERR);
    add(0, 1, 8'h12, ST_ERR,  0, 8'h00, 29'h0);
    add(1, 0, 8'h00, ST_BUSY, 0, 8'h00, 29'h0);
    add(0, 1, 8'h01, ST_BUSY, 0, 8'h00, 29'h0);
    add(0, 1, 8'h20, ST_ERR,  0, 8'h00, 29'h0);
    add(0, 0, 8'h00, ST_ERR,  0, 8'h00, 29'h0);
    add(1, 0, 8'h00, ST_BUSY, 0, 8'h00, 29'h0);
    add_nominal(8'hE6, ST_DONE);

    in_rst = 1'b0; in_start = 1'b0; in_byte = 8'h00; in_byte_valid = 1'b0;
    repeat (2) @(negedge in_clk);
    chk_state("reset", ST_IDLE);
    chk("reset_wr_en", 32'(out_pm_wr_en), 32'd0);
    chk("reset_addr", 32'(out_pm_wr_addr), 32'd0);
    chk("reset_data", 32'(out_pm_wr_data), 32'd0);
    in_rst = 1'b1;
    @(negedge in_clk);

    for (int i = 0; i < vecs.size(); i++) begin
      in_start      = vecs[i].start;
      in_byte_valid = vecs[i].vld;
      in_byte       = vecs[i].b;
      @(negedge in_clk);
      chk_state($sformatf("vec%0d", i), vecs[i].st);
      chk($sformatf("vec%0d_wr", i), 32'(out_pm_wr_en), 32'(vecs[i].wr));
      if (vecs[i].wr) begin
        chk($sformatf("vec%0d_addr", i), 32'(out_pm_wr_addr), 32'(vecs[i].addr));
        chk($sformatf("vec%0d_data", i), 32'(out_pm_wr_data), 32'(vecs[i].data));
      end
    end
    in_start = 1'b0; in_byte_valid = 1'b0;
    @(negedge in_clk);

    // Gapped stream with in_start raised mid-DATA: same writes, same result.
    wq.delete();
    pulse_start();
    chk_state("gap_start", ST_BUSY);
    send_stream(nom, 1'b1, 3);
    @(negedge in_clk);
    chk_nominal_writes("gap");
    chk_state("gap_end", ST_DONE);

    // Full memory: N=0, instruction i = i, checksum is XOR of 0..255 = 0.
    wq.delete();
    full.push_back(8'h00);
    for (int i = 0; i < 256; i++) begin
      full.push_back(8'h00); full.push_back(8'h00); full.push_back(8'h00);
      full.push_back(8'(i));
    end
    full.push_back(8'h00);
    pulse_start();
    send_stream(full, 1'b0, -1);
    @(negedge in_clk);
    chk("full_nwr", 32'(wq.size()), 32'd256);
    begin
      int bad = 0;
      for (int i = 0; i < wq.size(); i++)
        if (wq[i].addr !== 8'(i) || wq[i].data !== 29'(i)) bad++;
      chk("full_bad_entries", 32'(bad), 32'd0);
    end
    chk_state("full_end", ST_DONE);

    // Async reset after two data bytes of instruction 0.
    wq.delete();
    pulse_start();
    send_stream('{8'h02, 8'h01, 8'h02}, 1'b0, -1);
    chk_state("pre_arst", ST_BUSY);
    #2 in_rst = 1'b0;
    #1;
    chk_state("arst", ST_IDLE);
    chk("arst_wr_en", 32'(out_pm_wr_en), 32'd0);
    chk("arst_addr", 32'(out_pm_wr_addr), 32'd0);
    chk("arst_data", 32'(out_pm_wr_data), 32'd0);
    @(negedge in_clk);
    in_rst = 1'b1;
    @(negedge in_clk);
    chk_state("arst_idle", ST_IDLE);
    pulse_start();
    send_stream(nom, 1'b0, -1);
    @(negedge in_clk);
    chk_nominal_writes("arst");
    chk_state("arst_end", ST_DONE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
